click_classifier: RTL and testbench
===================================

Name: click_classifier

Overview:
- Sits directly downstream of the debouncer: consumes its clean, glitch-free button level.
- Turns that level into single-cycle event pulses: raw press/release edges, single click, double click, long press.
- Pulses drive counters, menus or mode toggles in the top level, replacing a raw debounced level used as a clock.
- Fully synchronous to the system clock. No derived clocks.

Parameters:
- LONG_CYCLES, default 12000000: number of clk cycles the button must stay held to count as a long press (1 s at 12 MHz). Must be >= 2.
- DCLICK_CYCLES, default 3600000: maximum gap in clk cycles, after a short release, in which a second press makes a double click (300 ms). Must be >= 2.
- TW, default 24: timer width. Must satisfy 2^TW > max(LONG_CYCLES, DCLICK_CYCLES).

Ports:
- clk, input, 1: system clock; all logic on its rising edge.
- rst, input, 1: reset; synchronous and active-high.
- btn_in, input, 1: debounced button level from the debouncer; 1 = pressed.
- press_tick, output, 1: one-cycle pulse on each accepted rising edge of btn_in.
- release_tick, output, 1: one-cycle pulse on each accepted falling edge of btn_in.
- click, output, 1: one-cycle pulse for a single short click.
- dclick, output, 1: one-cycle pulse for a double click.
- lpress, output, 1: one-cycle pulse when the long-press threshold is reached.
- busy, output, 1: high while the FSM is not in IDLE.

Behaviour:
- Edge detect:
  - btn_q is a register of btn_in.
  - rise = btn_in & ~btn_q; fall = ~btn_in & btn_q.
  - btn_q resets to 1, so a button held through reset produces no press until it has been released.
- All outputs are registered. Each is 0 in reset and in the cycle following reset deassertion.
- press_tick and release_tick are high in the cycle after the clk edge at which rise or fall is detected, in every state.
- FSM states: IDLE, PRESS1, WAIT2, PRESS2, HOLD. Reset state is IDLE; timer resets to 0.
- Timer:
  - Cleared to 0 on every state entry.
  - Increments by 1 each cycle in PRESS1 and WAIT2.
  - Holds at 0 in all other states.
- IDLE:
  - rise -> PRESS1.
  - Otherwise stay.
- PRESS1:
  - fall -> WAIT2.
  - Else timer == LONG_CYCLES-1 -> HOLD, and lpress pulses.
  - lpress is therefore high exactly LONG_CYCLES cycles after press_tick.
- HOLD:
  - fall -> IDLE.
  - No click or dclick is produced for a long press.
- WAIT2:
  - rise -> PRESS2.
  - Else timer == DCLICK_CYCLES-1 -> IDLE, and click pulses. click is high DCLICK_CYCLES cycles after release_tick.
- PRESS2:
  - fall -> IDLE, and dclick pulses in the same cycle as release_tick.
  - No long-press detection in PRESS2; a held second press still ends as dclick on release.
- Simultaneous events:
  - PRESS1, fall in the same cycle as the timer limit: fall wins, giving a short press with no lpress.
  - WAIT2, rise in the same cycle as the timer limit: rise wins, giving PRESS2 with no click.
- At most one of click, dclick, lpress is high in any cycle. Each gesture yields exactly one classification pulse.
- busy = (state != IDLE), registered with the state.
- Reset mid-gesture:
  - rst high in any cycle forces IDLE and timer 0 at that edge.
  - Pending classifications are discarded; no pulse is emitted after reset.
  - Because btn_q resets to 1, a button still held after reset is ignored until released.

Test Plan (LONG_CYCLES=20, DCLICK_CYCLES=8, TW=5):
- Single click: btn_in high 5 cycles, then low 20 cycles -> press_tick once, release_tick once, click once 8 cycles after release_tick; dclick=0, lpress=0; busy falls with the click pulse.
- Double click: high 4, low 3, high 4, low 12 -> two press_ticks, two release_ticks, dclick once coincident with the 2nd release_tick; click=0, lpress=0.
- Long press: btn_in high 30 cycles, then low -> lpress once exactly 20 cycles after press_tick; release_tick on release; no click or dclick; busy low the cycle after release.
- Boundaries:
  - Release on the exact cycle timer hits 19 -> short press path, no lpress.
  - Second press on the exact cycle WAIT2 timer hits 7 -> dclick, no click.
  - Second press one cycle later -> click, then a new PRESS1 sequence.
- Reset: pulse rst for 1 cycle in PRESS1 with btn_in still high, then release btn_in after 25 cycles -> no lpress, no press_tick, no release_tick; all outputs 0; next clean press behaves as a fresh single click.
- Power-up held: btn_in=1 during and after rst -> no events until btn_in goes low then high; then normal press_tick.

Source files
------------

// File: rtl/click_classifier.sv
// Turns a debounced button level into single-cycle gesture pulses:
// press/release edges, single click, double click and long press.
module click_classifier #(
  parameter int unsigned LONG_CYCLES   = 12000000,
  parameter int unsigned DCLICK_CYCLES = 3600000,
  parameter int unsigned TW            = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press_tick,
  output logic release_tick,
  output logic click,
  output logic dclick,
  output logic lpress,
  output logic busy
);

  typedef enum logic [2:0] {StIdle, StPress1, StWait2, StPress2, StHold} state_e;

  localparam logic [TW-1:0] LongLast   = TW'(LONG_CYCLES - 1);
  localparam logic [TW-1:0] DclickLast = TW'(DCLICK_CYCLES - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          btn_q;
  logic          armed_q;
  logic          rise, fall, fall_acc;
  logic          press_q, release_q, click_q, dclick_q, lpress_q, busy_q;
  logic          click_d, dclick_d, lpress_d;

  assign rise     = btn_in & ~btn_q;
  assign fall     = ~btn_in & btn_q;
  // btn_q resets high, so the first low level seen after reset is not a real release.
  assign fall_acc = fall & armed_q;

  always_comb begin
    state_d  = state_q;
    timer_d  = '0;
    click_d  = 1'b0;
    dclick_d = 1'b0;
    lpress_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rise) state_d = StPress1;
      end
      StPress1: begin
        if (fall_acc) begin
          state_d = StWait2;
        end else if (timer_q == LongLast) begin
          state_d  = StHold;
          lpress_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StWait2: begin
        if (rise) begin
          state_d = StPress2;
        end else if (timer_q == DclickLast) begin
          state_d = StIdle;
          click_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StPress2: begin
        if (fall_acc) begin
          state_d  = StIdle;
          dclick_d = 1'b1;
        end
      end
      StHold: begin
        if (fall_acc) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      btn_q     <= 1'b1;
      armed_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      dclick_q  <= 1'b0;
      lpress_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      btn_q     <= btn_in;
      armed_q   <= armed_q | ~btn_in;
      press_q   <= rise;
      release_q <= fall_acc;
      click_q   <= click_d;
      dclick_q  <= dclick_d;
      lpress_q  <= lpress_d;
      busy_q    <= (state_d != StIdle);
    end
  end

  assign press_tick   = press_q;
  assign release_tick = release_q;
  assign click        = click_q;
  assign dclick       = dclick_q;
  assign lpress       = lpress_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_click_classifier.sv
// Directed bench for click_classifier with small thresholds (LONG=20, DCLICK=8).
module tb_click_classifier;

  localparam int unsigned L  = 20;
  localparam int unsigned D  = 8;
  localparam int unsigned TW = 5;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic press_tick, release_tick, click, dclick, lpress, busy;

  click_classifier #(
    .LONG_CYCLES  (L),
    .DCLICK_CYCLES(D),
    .TW           (TW)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .press_tick  (press_tick),
    .release_tick(release_tick),
    .click       (click),
    .dclick      (dclick),
    .lpress      (lpress),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int nchecks = 0;
  int cyc = 0;
  int np, nr, nc, nd, nl, nbusy, nmulti;
  int tp, tr, tc, tc0, td, tl, tbf;
  logic busy_at_rel;
  logic busy_prev = 1'b0;

  task automatic check_eq(input string tag, input int got, input int exp);
    nchecks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    np = 0; nr = 0; nc = 0; nd = 0; nl = 0; nbusy = 0;
    tp = -1; tr = -1; tc = -1; tc0 = -1; td = -1; tl = -1; tbf = -1;
    busy_at_rel = 1'b1;
  endtask

  task automatic step(input logic b);
    btn_in = b;
    @(posedge clk);
    #1;
    cyc++;
    if (press_tick) begin np++; tp = cyc; end
    if (release_tick) begin nr++; tr = cyc; busy_at_rel = busy; end
    if (click) begin if (nc == 0) tc0 = cyc; nc++; tc = cyc; end
    if (dclick) begin nd++; td = cyc; end
    if (lpress) begin nl++; tl = cyc; end
    if (busy) nbusy++;
    if (busy_prev && !busy) tbf = cyc;
    busy_prev = busy;
    if ((int'(click) + int'(dclick) + int'(lpress)) > 1) nmulti++;
  endtask

  task automatic run(input logic b, input int n);
    for (int i = 0; i < n; i++) step(b);
  endtask

  initial begin
    nmulti = 0;
    clear_stats();
    rst    = 1'b1;
    btn_in = 1'b0;
    run(1'b0, 3);
    check_eq("reset_outputs", int'({press_tick, release_tick, click, dclick, lpress, busy}), 0);
    rst = 1'b0;

    // Idle after reset with button up: no spurious release.
    clear_stats();
    run(1'b0, 3);
    check_eq("idle_no_release", nr, 0);
    check_eq("idle_no_busy", nbusy, 0);

    // Single click.
    clear_stats();
    run(1'b1, 5);
    run(1'b0, 20);
    check_eq("sc_press", np, 1);
    check_eq("sc_release", nr, 1);
    check_eq("sc_click", nc, 1);
    check_eq("sc_click_delay", tc - tr, int'(D));
    check_eq("sc_dclick", nd, 0);
    check_eq("sc_lpress", nl, 0);
    check_eq("sc_busy_fall", tbf, tc);

    // Double click.
    clear_stats();
    run(1'b1, 4);
    run(1'b0, 3);
    run(1'b1, 4);
    run(1'b0, 12);
    check_eq("dc_press", np, 2);
    check_eq("dc_release", nr, 2);
    check_eq("dc_dclick", nd, 1);
    check_eq("dc_dclick_time", td, tr);
    check_eq("dc_click", nc, 0);
    check_eq("dc_lpress", nl, 0);

    // Long press.
    clear_stats();
    run(1'b1, 30);
    run(1'b0, 5);
    check_eq("lp_lpress", nl, 1);
    check_eq("lp_delay", tl - tp, int'(L));
    check_eq("lp_release", nr, 1);
    check_eq("lp_click", nc, 0);
    check_eq("lp_dclick", nd, 0);
    check_eq("lp_busy_at_rel", int'(busy_at_rel), 0);

    // Release exactly when the long-press timer reaches its limit: fall wins.
    clear_stats();
    run(1'b1, int'(L));
    run(1'b0, 20);
    check_eq("b1_lpress", nl, 0);
    check_eq("b1_click", nc, 1);

    // Second press exactly at the double-click limit: rise wins.
    clear_stats();
    run(1'b1, 3);
    run(1'b0, int'(D));
    run(1'b1, 3);
    run(1'b0, 12);
    check_eq("b2_dclick", nd, 1);
    check_eq("b2_click", nc, 0);

    // Second press one cycle late: click, then a fresh single click.
    clear_stats();
    run(1'b1, 3);
    run(1'b0, int'(D) + 1);
    run(1'b1, 3);
    run(1'b0, 20);
    check_eq("b3_click", nc, 2);
    check_eq("b3_press", np, 2);
    check_eq("b3_dclick", nd, 0);
    check_eq("b3_click_then_press", tp - tc0, 1);

    // Reset in PRESS1 with the button still held.
    clear_stats();
    run(1'b1, 5);
    clear_stats();
    rst = 1'b1;
    step(1'b1);
    check_eq("rm_outputs", int'({press_tick, release_tick, click, dclick, lpress, busy}), 0);
    rst = 1'b0;
    run(1'b1, 25);
    run(1'b0, 25);
    check_eq("rm_press", np, 0);
    check_eq("rm_release", nr, 0);
    check_eq("rm_lpress", nl, 0);
    check_eq("rm_events", nc + nd, 0);
    check_eq("rm_busy", nbusy, 0);
    clear_stats();
    run(1'b1, 5);
    run(1'b0, 20);
    check_eq("rm_fresh_click", nc, 1);
    check_eq("rm_fresh_press", np, 1);
    check_eq("rm_fresh_release", nr, 1);

    // Button held through power-up reset.
    clear_stats();
    rst = 1'b1;
    run(1'b1, 3);
    rst = 1'b0;
    run(1'b1, 10);
    check_eq("pu_press", np, 0);
    check_eq("pu_busy", nbusy, 0);
    run(1'b0, 3);
    check_eq("pu_release", nr, 0);
    run(1'b1, 3);
    check_eq("pu_new_press", np, 1);
    run(1'b0, 20);
    check_eq("pu_click", nc, 1);

    check_eq("one_hot_class", nmulti, 0);

    $display("Result: errors=%0d of %0d checks", errs, nchecks);
    $finish;
  end

endmodule
